// File: rtl/sp_ram_arbiter_if.sv
// sp_ram_arbiter_if: two requester ports (A, B) sharing one single-port RAM through sp_ram_arbiter.
interface sp_ram_arbiter_if #(
  parameter int DATA = 8,
  parameter int ADDR = 10
);
  logic            a_req, b_req;
  logic            a_wr, b_wr;
  logic [ADDR-1:0] a_addr, b_addr;
  logic [DATA-1:0] a_din, b_din;
  logic            a_gnt, b_gnt;
  logic            a_rvalid, b_rvalid;
  logic [DATA-1:0] a_dout, b_dout;
  modport master (
    output a_req, a_wr, a_addr, a_din, b_req, b_wr, b_addr, b_din,
    input  a_gnt, a_rvalid, a_dout, b_gnt, b_rvalid, b_dout
  );
  modport slave (
    input  a_req, a_wr, a_addr, a_din, b_req, b_wr, b_addr, b_din,
    output a_gnt, a_rvalid, a_dout, b_gnt, b_rvalid, b_dout
  );
endinterface

// File: rtl/sp_ram_arbiter.sv
// sp_ram_arbiter: one-grant-per-cycle arbiter in front of a registered-read single-port RAM.
// Round-robin by default; SP_RAM_ARB_FIXED_PRIO_EN selects A-first with a B starvation bound.
module sp_ram_arbiter #(
  parameter int DATA     = 8,
  parameter int ADDR     = 10,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  sp_ram_arbiter_if.slave bus,
  output logic            ram_wr_o,
  output logic [ADDR-1:0] ram_addr_o,
  output logic [DATA-1:0] ram_din_o,
  input  logic [DATA-1:0] ram_dout_i
);
  if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
    $error("MAX_WAIT must be 1..255");
  end
  logic            ready_q;
  logic            a_win;
  logic            pend_a_q, pend_a_d, pend_b_q, pend_b_d;
  logic [DATA-1:0] a_dout_q, a_dout_d, b_dout_q, b_dout_d;
`ifdef SP_RAM_ARB_FIXED_PRIO_EN
  logic [7:0] wait_q, wait_d;
  assign a_win = wait_q < 8'(MAX_WAIT);
  always_comb wait_d = bus.b_gnt ? 8'd0 : (bus.b_req && ready_q) ? wait_q + 8'd1 : wait_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wait_q <= 8'd0;
    else        wait_q <= wait_d;
`else
  // last_q = 1 means B was granted most recently, so A wins the next tie
  logic last_q, last_d;
  assign a_win = last_q;
  always_comb last_d = bus.a_gnt ? 1'b0 : bus.b_gnt ? 1'b1 : last_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
`endif
  assign bus.a_gnt = ready_q && bus.a_req && (!bus.b_req || a_win);
  assign bus.b_gnt = ready_q && bus.b_req && !bus.a_gnt;
  assign ram_wr_o   = (bus.a_gnt && bus.a_wr) || (bus.b_gnt && bus.b_wr);
  assign ram_addr_o = bus.b_gnt ? bus.b_addr : bus.a_addr;
  assign ram_din_o  = bus.b_gnt ? bus.b_din : bus.a_din;
  assign pend_a_d = bus.a_gnt && !bus.a_wr;
  assign pend_b_d = bus.b_gnt && !bus.b_wr;
  // read data is shown in the rvalid cycle and held afterwards
  assign a_dout_d = pend_a_q ? ram_dout_i : a_dout_q;
  assign b_dout_d = pend_b_q ? ram_dout_i : b_dout_q;
  assign bus.a_rvalid = pend_a_q;
  assign bus.b_rvalid = pend_b_q;
  assign bus.a_dout   = a_dout_d;
  assign bus.b_dout   = b_dout_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ready_q  <= 1'b0;
      pend_a_q <= 1'b0;
      pend_b_q <= 1'b0;
      a_dout_q <= '0;
      b_dout_q <= '0;
    end else begin
      ready_q  <= 1'b1;
      pend_a_q <= pend_a_d;
      pend_b_q <= pend_b_d;
      a_dout_q <= a_dout_d;
      b_dout_q <= b_dout_d;
    end
endmodule

// File: tb/tb_sp_ram_arbiter.sv
// tb_sp_ram_arbiter: directed vector bench for sp_ram_arbiter with a behavioural read-first RAM.
module tb_sp_ram_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ram_wr;
  logic [9:0] ram_addr;
  logic [7:0] ram_din, ram_dout;
  logic [7:0] mem [1024];
  logic       filled = 1'b0;
  int         n_vec = 0, n_err = 0;
  sp_ram_arbiter_if ifc ();
  sp_ram_arbiter dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc),
    .ram_wr_o(ram_wr), .ram_addr_o(ram_addr), .ram_din_o(ram_din), .ram_dout_i(ram_dout)
  );
  always #5 clk = ~clk;
  // preset contents: mem[x] = x[7:0] ^ 8'hC3
  always @(posedge clk) begin
    if (!filled) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'(i) ^ 8'hC3;
      filled <= 1'b1;
    end else if (ram_wr) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end
  typedef struct {
    logic a_req, a_wr; logic [9:0] a_addr; logic [7:0] a_din;
    logic b_req, b_wr; logic [9:0] b_addr; logic [7:0] b_din;
    logic [38:0] exp;
  } vec_t;
  logic [38:0] obs;
  assign obs = {ifc.a_gnt, ifc.b_gnt, ram_wr, ifc.a_rvalid, ifc.b_rvalid,
                ifc.a_dout, ifc.b_dout, ram_addr, ram_din};
  function automatic vec_t mk(input logic ar, aw, input logic [9:0] aa, input logic [7:0] ad,
                              input logic br, bw, input logic [9:0] ba, input logic [7:0] bd,
                              input logic [1:0] gnt, input logic wr, input logic [1:0] rv,
                              input logic [7:0] ado, bdo, input logic [9:0] ra, input logic [7:0] rd);
    vec_t v;
    v.a_req = ar; v.a_wr = aw; v.a_addr = aa; v.a_din = ad;
    v.b_req = br; v.b_wr = bw; v.b_addr = ba; v.b_din = bd;
    v.exp = {gnt, wr, rv, ado, bdo, ra, rd};
    return v;
  endfunction
  task automatic apply(input vec_t v, input string nm);
    ifc.a_req = v.a_req; ifc.a_wr = v.a_wr; ifc.a_addr = v.a_addr; ifc.a_din = v.a_din;
    ifc.b_req = v.b_req; ifc.b_wr = v.b_wr; ifc.b_addr = v.b_addr; ifc.b_din = v.b_din;
    #1;
    n_vec++;
    if (obs !== v.exp) begin
      n_err++;
      $display("FAIL %s: got {gnt,wr,rv,adout,bdout,raddr,rdin}=%h want %h", nm, obs, v.exp);
    end
    @(negedge clk);
  endtask
  vec_t idle, both;
  vec_t tbl [17];
  initial begin
    idle = mk(0,0,10'h000,8'h00, 0,0,10'h000,8'h00, 2'b00,0,2'b00, 8'h00,8'h00,10'h000,8'h00);
    both = mk(1,0,10'h010,8'h00, 1,0,10'h020,8'h00, 2'b00,0,2'b00, 8'h00,8'h00,10'h010,8'h00);
    tbl[0]  = both;
    tbl[1]  = mk(1,0,10'h010,8'h00, 1,0,10'h020,8'h00, 2'b10,0,2'b00, 8'h00,8'h00,10'h010,8'h00);
    tbl[2]  = mk(1,0,10'h011,8'h00, 1,0,10'h020,8'h00, 2'b01,0,2'b10, 8'hD3,8'h00,10'h020,8'h00);
    tbl[3]  = mk(1,0,10'h011,8'h00, 1,0,10'h021,8'h00, 2'b10,0,2'b01, 8'hD3,8'hE3,10'h011,8'h00);
    tbl[4]  = mk(1,1,10'h3F0,8'h5A, 0,0,10'h000,8'h00, 2'b10,1,2'b10, 8'hD2,8'hE3,10'h3F0,8'h5A);
    tbl[5]  = mk(1,0,10'h3F0,8'h00, 0,0,10'h000,8'h00, 2'b10,0,2'b00, 8'hD2,8'hE3,10'h3F0,8'h00);
    tbl[6]  = mk(0,0,10'h000,8'h00, 0,0,10'h000,8'h00, 2'b00,0,2'b10, 8'h5A,8'hE3,10'h000,8'h00);
    tbl[7]  = mk(0,0,10'h000,8'h00, 1,0,10'h000,8'h00, 2'b01,0,2'b00, 8'h5A,8'hE3,10'h000,8'h00);
    tbl[8]  = mk(0,0,10'h000,8'h00, 1,0,10'h001,8'h00, 2'b01,0,2'b01, 8'h5A,8'hC3,10'h001,8'h00);
    tbl[9]  = mk(0,0,10'h000,8'h00, 1,0,10'h002,8'h00, 2'b01,0,2'b01, 8'h5A,8'hC2,10'h002,8'h00);
    tbl[10] = mk(0,0,10'h000,8'h00, 1,0,10'h003,8'h00, 2'b01,0,2'b01, 8'h5A,8'hC1,10'h003,8'h00);
    tbl[11] = mk(0,0,10'h000,8'h00, 0,0,10'h000,8'h00, 2'b00,0,2'b01, 8'h5A,8'hC0,10'h000,8'h00);
    tbl[12] = mk(0,0,10'h000,8'h00, 0,0,10'h000,8'h00, 2'b00,0,2'b00, 8'h5A,8'hC0,10'h000,8'h00);
    tbl[13] = mk(1,0,10'h3F0,8'h00, 1,1,10'h3F0,8'hA7, 2'b10,0,2'b00, 8'h5A,8'hC0,10'h3F0,8'h00);
    tbl[14] = mk(0,0,10'h000,8'h00, 1,1,10'h3F0,8'hA7, 2'b01,1,2'b10, 8'h5A,8'hC0,10'h3F0,8'hA7);
    tbl[15] = mk(0,0,10'h000,8'h00, 1,0,10'h3F0,8'h00, 2'b01,0,2'b00, 8'h5A,8'hC0,10'h3F0,8'h00);
    tbl[16] = mk(0,0,10'h000,8'h00, 0,0,10'h000,8'h00, 2'b00,0,2'b01, 8'h5A,8'hA7,10'h000,8'h00);
    ifc.a_req = 1'b1; ifc.a_wr = 1'b0; ifc.a_addr = 10'h010; ifc.a_din = 8'h00;
    ifc.b_req = 1'b1; ifc.b_wr = 1'b0; ifc.b_addr = 10'h020; ifc.b_din = 8'h00;
    @(negedge clk);
    @(negedge clk);
    apply(both, "reset_state");
    rst_n = 1'b1;
`ifdef SP_RAM_ARB_FIXED_PRIO_EN
    apply(both, "fp_not_ready");
    begin
      logic pa = 1'b0, pb = 1'b0;
      logic [7:0] ado = 8'h00, bdo = 8'h00;
      for (int k = 0; k < 10; k++) begin
        logic bw;
        bw = (k % 5) == 4;
        ado = pa ? 8'hD3 : ado;
        bdo = pb ? 8'hE3 : bdo;
        apply(mk(1,0,10'h010,8'h00, 1,0,10'h020,8'h00, {!bw, bw},0,{pa, pb}, ado,bdo,
                 bw ? 10'h020 : 10'h010,8'h00), $sformatf("fp_cycle%0d", k));
        pa = !bw;
        pb = bw;
      end
    end
`else
    for (int i = 0; i < 17; i++) apply(tbl[i], $sformatf("vec%0d", i));
`endif
    rst_n = 1'b0;
    apply(idle, "mid_rst_hold");
    rst_n = 1'b1;
    apply(idle, "mid_rst_release");
    apply(mk(0,0,10'h000,8'h00, 1,0,10'h005,8'h00, 2'b01,0,2'b00, 8'h00,8'h00,10'h005,8'h00), "b_read_before_rst");
    rst_n = 1'b0;
    apply(idle, "pend_dropped");
    apply(idle, "no_late_rvalid");
    rst_n = 1'b1;
    apply(both, "post_rst_not_ready");
    apply(mk(1,0,10'h010,8'h00, 1,0,10'h020,8'h00, 2'b10,0,2'b00, 8'h00,8'h00,10'h010,8'h00), "post_rst_tie_a");
`ifndef SP_RAM_ARB_FIXED_PRIO_EN
    apply(mk(1,0,10'h011,8'h00, 1,0,10'h020,8'h00, 2'b01,0,2'b10, 8'hD3,8'h00,10'h020,8'h00), "post_rst_tie_b");
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
